// File: rtl/ce_stream_reader.sv
// ce_stream_reader
// Captures clock-enable-strobed words into a small circular buffer and
// re-presents them, oldest first, through a registered valid/ready handshake.
// Occupancy and a sticky overflow flag are exported for status readback.
module ce_stream_reader #(
   parameter int n     = 16,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_ce,
   input  logic [n-1:0]  in_data,
   output logic          out_valid,
   output logic [n-1:0]  out_data,
   input  logic          out_ready,
   output logic [AW:0]   level,
   output logic          overflow,
   input  logic          clr_ovf
);

   logic [n-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic          full;
   logic          pop;
   logic          push;
   logic          drop;
   logic [AW-1:0] rd_next;
   logic [AW:0]   level_next;
   logic [n-1:0]  head_next;

   // Handshake decode: a pop in the same cycle frees the slot a full-buffer strobe needs.
   always_comb begin
      full    = (level == (AW+1)'(DEPTH));
      pop     = out_valid & out_ready;
      push    = in_ce & (~full | pop);
      drop    = in_ce & full & ~pop;
      rd_next = rd_ptr + AW'(pop);

      // NOTE: every always_comb output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      level_next = level;
      if (push && !pop)
         level_next = level + 1'b1;
      else if (pop && !push)
         level_next = level - 1'b1;

      // The word landing this cycle may be the next head (empty buffer, or a
      // level-1 buffer with push and pop together), so bypass it from in_data.
      head_next = mem[rd_next];
      if (push && (wr_ptr == rd_next))
         head_next = in_data;
   end

   // Buffer storage: written on push, never reset.
   // NOTE: the storage array carries no reset; level and the pointers alone
   // decide which entries are meaningful, and leaving it unreset keeps it a
   // plain RAM instead of a bank of resettable flops.
   always_ff @(posedge clk) begin
      if (!rst && push)
         mem[wr_ptr] <= in_data;
   end

   // Pointers, occupancy and sticky overflow.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_next;
         level  <= level_next;
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

   // Registered output stage: head word and its valid flag; data holds when empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= (level_next != '0);
         if (level_next != '0)
            out_data <= head_next;
      end
   end

endmodule

// File: tb/tb_ce_stream_reader.sv
// tb_ce_stream_reader
// Self-checking bench for ce_stream_reader: a reference occupancy/overflow
// model plus a FIFO scoreboard of accepted words, compared at each pop.
module tb_ce_stream_reader;

   localparam int N     = 16;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_ce;
   logic [N-1:0]  in_data;
   logic          out_valid;
   logic [N-1:0]  out_data;
   logic          out_ready;
   logic [AW:0]   level;
   logic          overflow;
   logic          clr_ovf;

   int vectors    = 0;
   int miscompares = 0;

   logic [N-1:0] sb_q[$];
   int           m_level = 0;
   logic         m_ovf   = 1'b0;

   ce_stream_reader #(.n(N), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_ce     (in_ce),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   // advance one rising edge, then sample 1 ns later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of stimulus; the scoreboard consumes on model pops and
   // records accepted words, and the model tracks level and overflow.
   task automatic drive_cycle(input logic ce, input logic [N-1:0] d,
                              input logic rdy, input logic clr);
      logic m_pop, m_push, m_drop;
      logic [N-1:0] exp_word;
      in_ce = ce; in_data = d; out_ready = rdy; clr_ovf = clr;
      m_pop  = (m_level != 0) && rdy;
      m_push = ce && ((m_level < DEPTH) || m_pop);
      m_drop = ce && !m_push;
      vectors++;
      if (out_valid !== (m_level != 0)) begin
         miscompares++;
         $display("FAIL valid_pre: got %b expected %b", out_valid, (m_level != 0));
      end
      if (m_pop) begin
         exp_word = sb_q.pop_front();
         vectors++;
         if (out_data !== exp_word) begin
            miscompares++;
            $display("FAIL pop_data: got %h expected %h", out_data, exp_word);
         end
      end
      if (m_push) sb_q.push_back(d);
      if (m_drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (m_push && !m_pop) m_level++;
      else if (m_pop && !m_push) m_level--;
      step();
      vectors++;
      if (level !== (AW+1)'(m_level) || overflow !== m_ovf) begin
         miscompares++;
         $display("FAIL status: got level=%0d ovf=%b expected level=%0d ovf=%b",
                  level, overflow, m_level, m_ovf);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_ce = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
      step(); step();
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++;
         if (out_valid !== 1'b0 || level !== '0 || overflow !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: got v=%b lvl=%0d ovf=%b d=%h expected 0 0 0 0000",
                     out_valid, level, overflow, out_data);
         end
      end
   endtask

   task automatic test_single_latency();
      drive_cycle(1'b1, 16'h1234, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 16'h1234 || level !== 3'd1) begin
         miscompares++;
         $display("FAIL single_latency: got v=%b d=%h lvl=%0d expected 1 1234 1",
                  out_valid, out_data, level);
      end
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++;
      if (out_valid !== 1'b0 || level !== 3'd0) begin
         miscompares++;
         $display("FAIL single_pop: got v=%b lvl=%0d expected 0 0", out_valid, level);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= 5; i++) drive_cycle(1'b1, N'(i), 1'b0, 1'b0);
      vectors++;
      if (level !== 3'd4 || overflow !== 1'b1 || out_data !== 16'h0001) begin
         miscompares++;
         $display("FAIL fill_ovf: got lvl=%0d ovf=%b d=%h expected 4 1 0001",
                  level, overflow, out_data);
      end
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++;
      if (out_valid !== 1'b0 || sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL fill_drain: got v=%b left=%0d expected 0 0", out_valid, sb_q.size());
      end
      drive_cycle(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 16'h00A0 + N'(i), 1'b0, 1'b0);
      drive_cycle(1'b1, 16'h00A4, 1'b1, 1'b0);
      vectors++;
      if (level !== 3'd4 || overflow !== 1'b0 || out_data !== 16'h00A1) begin
         miscompares++;
         $display("FAIL full_push_pop: got lvl=%0d ovf=%b d=%h expected 4 0 00a1",
                  level, overflow, out_data);
      end
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++) begin
         drive_cycle(1'b1, N'(i), 1'b1, 1'b0);
         vectors++;
         if (out_valid !== 1'b1 || level !== 3'd1 || out_data !== N'(i)) begin
            miscompares++;
            $display("FAIL stream[%0d]: got v=%b lvl=%0d d=%h expected 1 1 %h",
                     i, out_valid, level, out_data, N'(i));
         end
      end
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_priority_and_reset();
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 16'hC000 + N'(i), 1'b0, 1'b0);
      drive_cycle(1'b1, 16'hBEEF, 1'b0, 1'b1);
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL set_wins: got %b expected 1", overflow);
      end
      drive_cycle(1'b0, '0, 1'b0, 1'b1);
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_ovf: got %b expected 0", overflow);
      end
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++;
      if (level !== 3'd3) begin
         miscompares++;
         $display("FAIL pre_reset_level: got %0d expected 3", level);
      end
      rst = 1'b1; in_ce = 1'b1; in_data = 16'hDEAD; out_ready = 1'b1; clr_ovf = 1'b0;
      step();
      rst = 1'b0; in_ce = 1'b0; out_ready = 1'b0;
      model_reset();
      vectors++;
      if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: got v=%b lvl=%0d ovf=%b expected 0 0 0",
                  out_valid, level, overflow);
      end
      drive_cycle(1'b1, 16'h5A5A, 1'b0, 1'b0);
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_latency();
      test_fill_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_priority_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
